arbiter_game_countdown: RTL and testbench

Pre-game countdown stage of the arbiter game. Sits directly upstream of the game FSM: consumes the FSM's countdown-reset output (`cd_rst_out`) and produces the `cd_done` input that releases the FSM into its waiting state. While counting it drives a bank of countdown LEDs that turn off one per tick, plus a one-cycle tick pulse for an optional buzzer.

---
 rtl/arbiter_game_countdown.sv | 102 ++++++++++
 tb/tb_arbiter_game_countdown.sv | 134 +++++++++++++
 2 files changed

// File: rtl/arbiter_game_countdown.sv
// Pre-game countdown: lights all LEDs, darkens one per TICK_DIV cycles,
// then raises cd_done_out until the game FSM clears it again.
module arbiter_game_countdown #(
    parameter int TICK_DIV = 12000000,
    parameter int N_STEPS  = 3
) (
    input  logic               clk,
    input  logic               rst_in,
    input  logic               cd_rst_in,
    output logic               cd_done_out,
    output logic [N_STEPS-1:0] leds_out,
    output logic               tick_out
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [N_STEPS-1:0] LEDS_ALL = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [N_STEPS-1:0] leds_q, leds_d;
    logic               done_q, done_d;
    logic               tick_q, tick_d;
    logic [N_STEPS-1:0] leds_shift;

    assign leds_shift = leds_q >> 1;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        leds_d  = leds_q;
        done_d  = done_q;
        tick_d  = 1'b0;
        if (rst_in || cd_rst_in) begin
            state_d = IDLE;
            pre_d   = '0;
            leds_d  = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = COUNT;
                    pre_d   = '0;
                    leds_d  = LEDS_ALL;
                    done_d  = 1'b0;
                end
                COUNT: begin
                    if (pre_q != PRE_MAX) begin
                        pre_d = pre_q + PW'(1);
                    end else begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                        leds_d = leds_shift;
                        // last LED just went dark: finish on this same edge
                        if (leds_shift == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    pre_d  = '0;
                    leds_d = '0;
                    done_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    pre_d   = '0;
                    leds_d  = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q <= IDLE;
            pre_q   <= '0;
            leds_q  <= '0;
            done_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            leds_q  <= leds_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
        end
    end

    assign cd_done_out = done_q;
    assign leds_out    = leds_q;
    assign tick_out    = tick_q;

endmodule

// File: tb/tb_arbiter_game_countdown.sv
// Scoreboard bench for arbiter_game_countdown (TICK_DIV=4, N_STEPS=3).
// Expected outputs come from a timeline model counting edges since E0.
module tb_arbiter_game_countdown;

    localparam int T = 4;
    localparam int N = 3;
    localparam logic [N-1:0] ALL = '1;

    typedef struct packed {
        logic [N-1:0] leds;
        logic         done;
        logic         tick;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_in = 1'b1;
    logic         cd_rst_in = 1'b0;
    logic         cd_done_out;
    logic [N-1:0] leds_out;
    logic         tick_out;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sbq[$];

    bit   m_run = 1'b0;
    int   m_n = 0;

    arbiter_game_countdown #(
        .TICK_DIV(T),
        .N_STEPS (N)
    ) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .cd_rst_in  (cd_rst_in),
        .cd_done_out(cd_done_out),
        .leds_out   (leds_out),
        .tick_out   (tick_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    // advance the timeline model by one clock edge
    function automatic exp_t model(input logic r, input logic c);
        exp_t e;
        int   k;
        if (r || c) begin
            m_run = 1'b0;
            m_n   = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_n   = 0;
        end else begin
            m_n++;
        end
        e = '0;
        if (m_run) begin
            k      = m_n / T;
            e.leds = (k >= N) ? '0 : (ALL >> k);
            e.done = (m_n >= N * T);
            e.tick = (m_n > 0) && (m_n % T == 0) && (m_n <= N * T);
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic c);
        exp_t e;
        @(negedge clk);
        rst_in    = r;
        cd_rst_in = c;
        sbq.push_back(model(r, c));
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("leds", 32'(leds_out), 32'(e.leds));
        chk("done", 32'(cd_done_out), 32'(e.done));
        chk("tick", 32'(tick_out), 32'(e.tick));
    endtask

    task automatic run(input logic r, input logic c, input int cyc);
        for (int i = 0; i < cyc; i++) step(r, c);
    endtask

    int lat;

    initial begin
        // reset held, then simultaneous resets
        run(1'b1, 1'b0, 5);
        run(1'b1, 1'b1, 1);
        // full countdown and hold in DONE
        run(1'b0, 1'b0, 13 + 20);
        run(1'b0, 1'b1, 2);
        // abort mid-count at E0+6, then fresh countdown
        run(1'b0, 1'b0, 6);
        run(1'b0, 1'b1, 1);
        run(1'b0, 1'b0, 14);
        run(1'b0, 1'b1, 1);
        // collision with the step edge E0+8
        run(1'b0, 1'b0, 8);
        run(1'b0, 1'b1, 2);
        // one-cycle release: LEDs on once, no tick
        run(1'b0, 1'b0, 1);
        run(1'b0, 1'b1, 2);
        // global reset mid-count
        run(1'b0, 1'b0, 5);
        run(1'b1, 1'b0, 1);
        // FSM-style loop: release, wait for done, reassert cd_rst
        lat = 0;
        while (lat < 40) begin
            step(1'b0, 1'b0);
            lat++;
            if (cd_done_out === 1'b1) break;
        end
        chk("latency", 32'(lat), 32'd13);
        run(1'b0, 1'b1, 1);
        // random cd_rst pattern, mostly low
        for (int i = 0; i < 300; i++) begin
            step(1'b0, ($urandom_range(0, 19) == 0));
        end
        chk("sbq_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

endmodule
